// File: rtl/result_drain_ctrl.sv
// -----------------------------------------------------------------------------
// result_drain_ctrl
//
// Drains the N x N banked result RAM once the systolic array has finished a
// matrix. Every element is read back and streamed out in row-major order on a
// valid/ready interface, followed by a one-cycle done pulse.
//
// Element (row r, col c) with r = rs*N+i and c = cs*N+j lives in bank[i][j]
// at address rs*w_seg_cnt+cs. Bank [i][j] maps to bit (i*N+j) of
// ram_c_rden_o and to slice (i*N+j) of ram_c_q_i.
//
// Ports:
//   clk_i         clock
//   rst_ni        synchronous active-low reset
//   start_i       one-cycle start pulse (array controller calc_done)
//   a_seg_cnt_i   row segment count, sampled on start   (rows = a*N)
//   w_seg_cnt_i   column segment count, sampled on start (cols = w*N)
//   ram_c_addr_o  read address broadcast to every bank
//   ram_c_rden_o  one-hot per-bank read enable
//   ram_c_q_i     bank read data, valid the cycle after the read enable
//   out_data_o    result element (FIFO head)
//   out_valid_o   out_data_o valid
//   out_ready_i   consumer ready
//   out_last_o    final element of the matrix
//   busy_o        high from the cycle after start through the done cycle
//   done_o        one-cycle pulse after the last element transfers
// -----------------------------------------------------------------------------
module result_drain_ctrl #(
  parameter int N  = 2,
  parameter int C  = 8,
  parameter int DW = 32
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                start_i,
  input  logic [6:0]          a_seg_cnt_i,
  input  logic [6:0]          w_seg_cnt_i,
  output logic [C-1:0]        ram_c_addr_o,
  output logic [N*N-1:0]      ram_c_rden_o,
  input  logic [N*N*DW-1:0]   ram_c_q_i,
  output logic [DW-1:0]       out_data_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                out_last_o,
  output logic                busy_o,
  output logic                done_o
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int BW = (N > 1) ? $clog2(N * N) : 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [6:0]    a_cnt_q, a_cnt_d;
  logic [6:0]    w_cnt_q, w_cnt_d;
  logic [6:0]    rs_q, rs_d;
  logic [6:0]    cs_q, cs_d;
  logic [IW-1:0] i_q, i_d;
  logic [IW-1:0] j_q, j_d;
  logic          pend_q, pend_d;
  logic [BW-1:0] pend_bank_q, pend_bank_d;
  logic          pend_last_q, pend_last_d;
  logic [DW-1:0] fifo_data_q [2];
  logic [1:0]    fifo_last_q;
  logic          wr_ptr_q;
  logic          rd_ptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          busy_q;
  logic          done_q;

  logic          issue_s;
  logic          last_elem_s;
  logic [13:0]   addr_full_s;
  logic [BW-1:0] bank_s;
  logic [DW-1:0] q_sel_s;
  logic [DW-1:0] head_data_s;
  logic          head_last_s;
  logic          head_valid_s;
  logic          pop_s;
  logic          push_s;
  logic          drop_s;

  // Read-issue decision, current bank/address and end-of-matrix detection
  always_comb begin
    addr_full_s = 14'(rs_q) * 14'(w_cnt_q) + 14'(cs_q);
    bank_s      = BW'(int'(i_q) * N + int'(j_q));
    // Credit: registered FIFO entries plus the read whose data is on ram_c_q_i
    issue_s     = (state_q == ST_RUN) && ((cnt_q + {1'b0, pend_q}) < 2'd2);
    last_elem_s = (rs_q == a_cnt_q - 7'd1) && (i_q == IDX_LAST) &&
                  (cs_q == w_cnt_q - 7'd1) && (j_q == IDX_LAST);
  end

  // One-hot read strobe with the broadcast address
  always_comb begin
    ram_c_rden_o = '0;
    if (issue_s) begin
      ram_c_rden_o[bank_s] = 1'b1;
      ram_c_addr_o         = C'(addr_full_s);
    end else begin
      ram_c_addr_o = '0;
    end
  end

  // FIFO head selection and push/pop bookkeeping
  always_comb begin
    q_sel_s = ram_c_q_i[int'(pend_bank_q) * DW +: DW];
    // An empty FIFO falls through to the returning read data so the first
    // beat appears in the same cycle the bank delivers it.
    if (cnt_q != 2'd0) begin
      head_data_s = fifo_data_q[rd_ptr_q];
      head_last_s = fifo_last_q[rd_ptr_q];
    end else begin
      head_data_s = q_sel_s;
      head_last_s = pend_last_q;
    end
    head_valid_s = (cnt_q != 2'd0) || pend_q;
    pop_s        = head_valid_s && out_ready_i;
    // Returning data is stored unless it was consumed straight through
    push_s       = pend_q && !((cnt_q == 2'd0) && pop_s);
    drop_s       = pop_s && (cnt_q != 2'd0);
    cnt_d        = cnt_q + {1'b0, push_s} - {1'b0, drop_s};
  end

  // Output stream driven from the FIFO head, zero when idle
  always_comb begin
    out_valid_o = head_valid_s;
    if (head_valid_s) begin
      out_data_o = head_data_s;
      out_last_o = head_last_s;
    end else begin
      out_data_o = '0;
      out_last_o = 1'b0;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;

  // Sequencer next state and rs/i/cs/j iteration (j innermost)
  always_comb begin
    state_d     = state_q;
    a_cnt_d     = a_cnt_q;
    w_cnt_d     = w_cnt_q;
    rs_d        = rs_q;
    cs_d        = cs_q;
    i_d         = i_q;
    j_d         = j_q;
    pend_d      = issue_s;
    pend_bank_d = bank_s;
    pend_last_d = issue_s && last_elem_s;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          a_cnt_d = a_seg_cnt_i;
          w_cnt_d = w_seg_cnt_i;
          rs_d    = 7'd0;
          cs_d    = 7'd0;
          i_d     = {IW{1'b0}};
          j_d     = {IW{1'b0}};
          if ((a_seg_cnt_i != 7'd0) && (w_seg_cnt_i != 7'd0)) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (issue_s) begin
          if (j_q == IDX_LAST) begin
            j_d = {IW{1'b0}};
            if (cs_q == w_cnt_q - 7'd1) begin
              cs_d = 7'd0;
              if (i_q == IDX_LAST) begin
                i_d  = {IW{1'b0}};
                rs_d = rs_q + 7'd1;
              end else begin
                i_d = i_q + IW'(1);
              end
            end else begin
              cs_d = cs_q + 7'd1;
            end
          end else begin
            j_d = j_q + IW'(1);
          end
          if (last_elem_s) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: begin
        // Leave on the edge that empties the pipeline so done follows the
        // last transfer by exactly one cycle.
        if ((cnt_d == 2'd0) && !pend_d) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counters, read pipeline, FIFO storage and status registers
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q        <= ST_IDLE;
      a_cnt_q        <= 7'd0;
      w_cnt_q        <= 7'd0;
      rs_q           <= 7'd0;
      cs_q           <= 7'd0;
      i_q            <= {IW{1'b0}};
      j_q            <= {IW{1'b0}};
      pend_q         <= 1'b0;
      pend_bank_q    <= {BW{1'b0}};
      pend_last_q    <= 1'b0;
      fifo_data_q[0] <= {DW{1'b0}};
      fifo_data_q[1] <= {DW{1'b0}};
      fifo_last_q    <= 2'b00;
      wr_ptr_q       <= 1'b0;
      rd_ptr_q       <= 1'b0;
      cnt_q          <= 2'd0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_cnt_q     <= a_cnt_d;
      w_cnt_q     <= w_cnt_d;
      rs_q        <= rs_d;
      cs_q        <= cs_d;
      i_q         <= i_d;
      j_q         <= j_d;
      pend_q      <= pend_d;
      pend_bank_q <= pend_bank_d;
      pend_last_q <= pend_last_d;
      cnt_q       <= cnt_d;
      busy_q      <= (state_d != ST_IDLE);
      done_q      <= (state_d == ST_DONE);
      if (push_s) begin
        fifo_data_q[wr_ptr_q] <= q_sel_s;
        fifo_last_q[wr_ptr_q] <= pend_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (drop_s) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
    end
  end

endmodule

// File: tb/tb_result_drain_ctrl.sv
// -----------------------------------------------------------------------------
// tb_result_drain_ctrl
//
// Directed bench for result_drain_ctrl (N=2, C=8, DW=32). A behavioural model
// of the banked result RAM returns addr*100 + 10*i + j from bank[i][j], so the
// expected row-major stream can be written down from row/column alone.
// -----------------------------------------------------------------------------
module tb_result_drain_ctrl;

  localparam int N  = 2;
  localparam int C  = 8;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [6:0]        a_seg;
  logic [6:0]        w_seg;
  logic [C-1:0]      addr;
  logic [N*N-1:0]    rden;
  logic [N*N*DW-1:0] ram_q = '0;
  logic [DW-1:0]     data;
  logic              valid;
  logic              ready;
  logic              last;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  logic [31:0] beats[$];
  logic        lasts[$];
  int issued, accepted, done_cnt, done_cyc, first_rden_cyc, first_valid_cyc;
  int first_acc_cyc, last_acc_cyc, busy_cycles, valid_cycles;
  int rd_err, credit_err, hold_err, onehot_err;
  logic timed_out;

  result_drain_ctrl #(.N(N), .C(C), .DW(DW)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .start_i      (start),
    .a_seg_cnt_i  (a_seg),
    .w_seg_cnt_i  (w_seg),
    .ram_c_addr_o (addr),
    .ram_c_rden_o (rden),
    .ram_c_q_i    (ram_q),
    .out_data_o   (data),
    .out_valid_o  (valid),
    .out_ready_i  (ready),
    .out_last_o   (last),
    .busy_o       (busy),
    .done_o       (done)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_val(input int b, input int a);
    return 32'(a * 100 + 10 * (b / N) + (b % N));
  endfunction

  // Result RAM model: registered read per bank
  always @(posedge clk) begin
    for (int b = 0; b < N * N; b++) begin
      if (rden[b]) ram_q[b*DW +: DW] <= mem_val(b, int'(addr));
    end
  end

  function automatic logic [31:0] exp_val(input int n, input int a, input int w);
    int cols, r, c;
    cols = w * N;
    r = n / cols;
    c = n % cols;
    return 32'(((r / N) * w + (c / N)) * 100 + 10 * (r % N) + (c % N));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One drain run: cycle 0 carries the start pulse; stops 3 cycles after done
  task automatic drain(input logic [6:0] a, input logic [6:0] w, input int stall_pct,
                       input int restart_at, input int abort_after);
    int cols, r, c, eb, ea;
    logic [N*N-1:0] exp_rden;
    logic pv, pl;
    logic [31:0] pd;
    cols = int'(w) * N;
    beats.delete(); lasts.delete();
    issued = 0; accepted = 0; done_cnt = 0; done_cyc = -1;
    first_rden_cyc = -1; first_valid_cyc = -1; first_acc_cyc = -1; last_acc_cyc = -1;
    busy_cycles = 0; valid_cycles = 0;
    rd_err = 0; credit_err = 0; hold_err = 0; onehot_err = 0;
    timed_out = 1'b0;
    pv = 1'b0; pl = 1'b0; pd = 32'd0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk); #1;
      start = (cyc == 0) || (cyc == restart_at);
      if (cyc == 0) begin
        a_seg = a; w_seg = w;
      end else begin
        a_seg = 7'd3; w_seg = 7'd1;   // must be ignored until the next start
      end
      ready = ($urandom_range(0, 99) >= stall_pct);
      #1;
      if (busy) busy_cycles++;
      if (done) begin
        if (done_cnt == 0) done_cyc = cyc;
        done_cnt++;
      end
      if (rden != '0) begin
        if (first_rden_cyc < 0) first_rden_cyc = cyc;
        if ($countones(rden) != 1) onehot_err++;
        if (issued - accepted >= 2) credit_err++;
        if (cols == 0) begin
          rd_err++;
        end else begin
          r = issued / cols; c = issued % cols;
          eb = (r % N) * N + (c % N);
          ea = (r / N) * int'(w) + c / N;
          exp_rden = '0;
          exp_rden[eb] = 1'b1;
          if (rden !== exp_rden || addr !== C'(ea)) rd_err++;
        end
        issued++;
      end
      if (valid) begin
        valid_cycles++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (pv && (!valid || data !== pd || last !== pl)) hold_err++;
      pv = valid && !ready; pd = data; pl = last;
      if (valid && ready) begin
        beats.push_back(data); lasts.push_back(last);
        accepted++;
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        last_acc_cyc = cyc;
      end
      if (abort_after >= 0 && accepted == abort_after) return;
      if (done_cnt > 0 && cyc >= done_cyc + 3) return;
    end
    timed_out = 1'b1;
  endtask

  task automatic check_seq(input string tag, input int a, input int w);
    int n, m;
    n = a * w * N * N;
    chk({tag, "_count"}, beats.size(), n);
    m = (beats.size() < n) ? beats.size() : n;
    for (int k = 0; k < m; k++) begin
      chk($sformatf("%s_beat%0d", tag, k), beats[k], exp_val(k, a, w));
      chk($sformatf("%s_last%0d", tag, k), 32'(lasts[k]), 32'(k == n - 1));
    end
    chk({tag, "_timeout"}, 32'(timed_out), 32'd0);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    chk({tag, "_rd_order"}, rd_err, 0);
    chk({tag, "_onehot"}, onehot_err, 0);
    chk({tag, "_credit"}, credit_err, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_addr"}, 32'(addr), 32'd0);
    chk({tag, "_rden"}, 32'(rden), 32'd0);
    chk({tag, "_valid"}, 32'(valid), 32'd0);
    chk({tag, "_last"}, 32'(last), 32'd0);
    chk({tag, "_data"}, data, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; a_seg = 7'd0; w_seg = 7'd0; ready = 1'b0;
    repeat (3) @(posedge clk);
    #1; rst_n = 1'b1;
    #1; check_reset_outputs("rst");

    // 1x1 segments: one tile, addr 0 in every bank -> 0, 1, 10, 11
    drain(7'd1, 7'd1, 0, -1, -1);
    check_seq("t1", 1, 1);
    chk("t1_first_rden", first_rden_cyc, 1);
    chk("t1_first_valid", first_valid_cyc, 2);
    chk("t1_done_cyc", done_cyc, 6);
    chk("t1_busy_cycles", busy_cycles, 6);

    // 2x3 segments, always ready: 24 beats, no bubbles
    drain(7'd2, 7'd3, 0, -1, -1);
    check_seq("t2", 2, 3);
    if (beats.size() > 23) begin
      chk("t2_r1c4", beats[10], 32'd210);   // bank[1][0] addr 2
      chk("t2_r3c5", beats[23], 32'd511);   // bank[1][1] addr 5
    end else begin
      chk("t2_short", beats.size(), 24);
    end
    chk("t2_first_valid", first_valid_cyc, 2);
    chk("t2_no_bubbles", last_acc_cyc - first_acc_cyc, 23);
    chk("t2_done_cyc", done_cyc, 26);

    // Same matrix with 30% consumer stalls
    drain(7'd2, 7'd3, 30, -1, -1);
    check_seq("t3", 2, 3);
    chk("t3_hold", hold_err, 0);

    // Zero row segments: straight to done
    drain(7'd0, 7'd3, 0, -1, -1);
    chk("t4_timeout", 32'(timed_out), 32'd0);
    chk("t4_reads", issued, 0);
    chk("t4_valid", valid_cycles, 0);
    chk("t4_done_cyc", done_cyc, 1);
    chk("t4_done_cnt", done_cnt, 1);
    chk("t4_busy_cycles", busy_cycles, 1);

    // Reset mid-run after 5 beats, then a clean full run
    drain(7'd2, 7'd3, 0, -1, 5);
    chk("t5_abort_beats", accepted, 5);
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    #1; check_reset_outputs("t5_rst");
    drain(7'd2, 7'd3, 0, -1, -1);
    check_seq("t5", 2, 3);

    // Second start while running is ignored
    drain(7'd2, 7'd3, 0, 8, -1);
    check_seq("t6", 2, 3);
    chk("t6_done_cyc", done_cyc, 26);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/result_drain_ctrl.md
Name: result_drain_ctrl

Overview:
- Downstream neighbour of the systolic array controller.
- Once the array has finished computing the result matrix into the N×N result RAM banks, this block reads every element back and streams it out in row-major order over a valid/ready interface.
- Typical consumers are an output FIFO or a host-readback path.
- It also drives the read side of the result RAMs; the array controller owns the write side.

Parameters:
- N, 2, systolic array dimension; number of result banks is N×N.
- C, 8, result RAM address width.
- DW, 32, result element width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; connected to the array controller's calc_done
- a_seg_cnt  in  7  row segment count; result rows = a_seg_cnt*N
- w_seg_cnt  in  7  column segment count; result cols = w_seg_cnt*N
- ram_c_addr  out  C  read address, broadcast to all banks
- ram_c_rden  out  N×N  per-bank read enable, at most one bit set
- ram_c_q  in  N×N×DW  bank read data, valid 1 cycle after rden
- out_data  out  DW  result element
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts when out_valid&&out_ready
- out_last  out  1  marks the final element of the matrix
- busy  out  1  high from the cycle after an accepted start until the done cycle, inclusive
- done  out  1  one-cycle pulse after the last element transfers

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all counters 0; output FIFO emptied; in-flight read discarded.
- Output reset values: ram_c_addr=0, ram_c_rden=0, out_valid=0, out_last=0, out_data=0, busy=0, done=0.
- a_seg_cnt and w_seg_cnt are sampled on start; later changes are ignored until the next start.
- Element mapping: row r = rs*N+i, col c = cs*N+j.
  - Element lives in bank[i][j] at address rs*w_seg_cnt+cs.
  - Address is computed as a 14-bit product-sum, truncated to C bits.
  - The bench constrains a_seg_cnt*w_seg_cnt ≤ 2^C.
- Iteration order (outermost to innermost): rs, i, cs, j, so output is strictly row-major.
- FSM states and transitions:
  - IDLE: start=1 with both counts nonzero → RUN. start=1 with either count 0 → DONE (no reads, no output beats).
  - RUN: issues at most one read per cycle, raising exactly one rden bit with the matching address. After the final element's read is issued → FLUSH.
  - FLUSH: waits until the FIFO is empty and no read is in flight → DONE.
  - DONE: done=1 for one cycle → IDLE.
- Read-issue flow control:
  - A read is issued only if FIFO occupancy plus in-flight reads is less than 2.
  - The FIFO is 2 entries deep; ram_c_q is captured into it 1 cycle after rden.
  - With out_ready held high, sustained throughput is 1 element per cycle.
- Latency: first ram_c_rden in the cycle after start; first out_valid 2 cycles after start.
- Output handshake:
  - out_data, out_valid and out_last come directly from the FIFO head.
  - Once out_valid is asserted, out_data and out_last stay stable until the beat is accepted.
  - The FIFO must never overflow and never drop a beat.
- out_last is high only on the element at row rows-1, col cols-1.
- done pulses the cycle after the out_last beat transfers.
- start while busy is ignored.
- start and reset asserted in the same cycle: reset wins.
- Simultaneous FIFO push and pop while full is legal; occupancy is unchanged.

Test Plan:
- a_seg_cnt=1, w_seg_cnt=1, out_ready=1, bank[i][j] addr0 = 10*i+j → beats 0,1,10,11; out_last on beat 4; done 6 cycles after start.
- a_seg_cnt=2, w_seg_cnt=3, out_ready=1 → 24 beats in row-major order; the row 1 / col 4 beat comes from bank[1][0] addr 2; one beat per cycle with no bubbles after the first.
- Same as previous case but out_ready toggling at random at 30% → identical 24-beat sequence; out_data held stable while stalled; rden never issued when FIFO occupancy plus in-flight reads equals 2.
- start with a_seg_cnt=0 → no rden and no out_valid; done pulses 1 cycle after start; busy high for exactly that cycle.
- rst_n=0 for one cycle mid-RUN (after beat 5 of 24) → all outputs reach reset values the next cycle; a new start then produces the full 24 beats from element 0.
- Second start pulse during RUN → ignored; beat count stays 24; exactly one done pulse.
